// File: rtl/bcd_divider.sv
// Sequential 7-digit packed-BCD restoring long divider.
// Fixed 71-cycle latency for valid operands, 2 cycles for error results.
module bcd_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [27:0] dividend,
    input  logic [27:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [27:0] quotient,
    output logic [27:0] remainder,
    output logic        div_by_zero,
    output logic        invalid
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        SUB,
        FINISH
    } state_t;

    state_t      state, state_n;
    logic [27:0] dvd, dvd_n;
    logic [27:0] dsr, dsr_n;
    logic [31:0] pr, pr_n;
    logic [27:0] qacc, qacc_n;
    logic [3:0]  qd, qd_n;
    logic [3:0]  att, att_n;
    logic [2:0]  d, d_n;
    logic        err_inv, err_inv_n;
    logic        err_dbz, err_dbz_n;
    logic        busy_n, done_n;
    logic [27:0] quotient_n, remainder_n;
    logic        div_by_zero_n, invalid_n;
    logic [32:0] sub_res;
    logic [3:0]  qd_t;
    logic [3:0]  dig;
    logic        bad;

    function automatic logic has_bad(input logic [27:0] v);
        logic b;
        b = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (v[4*i +: 4] > 4'd9) b = 1'b1;
        end
        return b;
    endfunction

    // a - b via nines-complement plus one; bit 32 set means no borrow
    function automatic logic [32:0] bcd_sub(
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [31:0] r;
        logic        c;
        logic [4:0]  s;
        r = '0;
        c = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s = {1'b0, a[4*i +: 4]}
              + {1'b0, 4'd9 - b[4*i +: 4]}
              + {4'b0, c};
            if (s > 5'd9) begin
                r[4*i +: 4] = s[3:0] + 4'd6;
                c = 1'b1;
            end else begin
                r[4*i +: 4] = s[3:0];
                c = 1'b0;
            end
        end
        return {c, r};
    endfunction

    assign sub_res = bcd_sub(pr, {4'h0, dsr});
    assign bad     = has_bad(dividend) | has_bad(divisor);

    always_comb begin
        dig = 4'h0;
        for (int i = 0; i < 7; i++) begin
            if (d == i[2:0]) dig = dvd[4*i +: 4];
        end
    end

    always_comb begin
        state_n       = state;
        dvd_n         = dvd;
        dsr_n         = dsr;
        pr_n          = pr;
        qacc_n        = qacc;
        qd_n          = qd;
        att_n         = att;
        d_n           = d;
        err_inv_n     = err_inv;
        err_dbz_n     = err_dbz;
        busy_n        = busy;
        done_n        = 1'b0;
        quotient_n    = quotient;
        remainder_n   = remainder;
        div_by_zero_n = div_by_zero;
        invalid_n     = invalid;
        qd_t          = qd;
        unique case (state)
            IDLE: begin
                if (start) begin
                    dvd_n     = dividend;
                    dsr_n     = divisor;
                    busy_n    = 1'b1;
                    state_n   = SHIFT;
                    d_n       = 3'd6;
                    qd_n      = 4'h0;
                    att_n     = 4'h0;
                    err_inv_n = bad;
                    err_dbz_n = !bad && (divisor == 28'h0);
                    qacc_n    = 28'h0;
                    pr_n      = 32'h0;
                    if (!bad && (divisor == 28'h0)) begin
                        qacc_n = 28'h9999999;
                        pr_n   = {4'h0, dividend};
                    end
                end
            end
            SHIFT: begin
                if (err_inv || err_dbz) begin
                    busy_n  = 1'b0;
                    state_n = FINISH;
                end else begin
                    pr_n    = {pr[27:0], dig};
                    qd_n    = 4'h0;
                    att_n   = 4'h0;
                    state_n = SUB;
                end
            end
            SUB: begin
                if (sub_res[32]) begin
                    pr_n = sub_res[31:0];
                    qd_t = qd + 4'd1;
                end
                qd_n  = qd_t;
                att_n = att + 4'd1;
                if (att == 4'd8) begin
                    for (int i = 0; i < 7; i++) begin
                        if (d == i[2:0]) qacc_n[4*i +: 4] = qd_t;
                    end
                    if (d == 3'd0) begin
                        state_n = FINISH;
                    end else begin
                        d_n     = d - 3'd1;
                        state_n = SHIFT;
                    end
                end
            end
            FINISH: begin
                done_n        = 1'b1;
                busy_n        = 1'b0;
                quotient_n    = qacc;
                remainder_n   = pr[27:0];
                invalid_n     = err_inv;
                div_by_zero_n = err_dbz;
                state_n       = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            dvd         <= '0;
            dsr         <= '0;
            pr          <= '0;
            qacc        <= '0;
            qd          <= '0;
            att         <= '0;
            d           <= '0;
            err_inv     <= 1'b0;
            err_dbz     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            invalid     <= 1'b0;
        end else begin
            state       <= state_n;
            dvd         <= dvd_n;
            dsr         <= dsr_n;
            pr          <= pr_n;
            qacc        <= qacc_n;
            qd          <= qd_n;
            att         <= att_n;
            d           <= d_n;
            err_inv     <= err_inv_n;
            err_dbz     <= err_dbz_n;
            busy        <= busy_n;
            done        <= done_n;
            quotient    <= quotient_n;
            remainder   <= remainder_n;
            div_by_zero <= div_by_zero_n;
            invalid     <= invalid_n;
        end
    end

endmodule

// File: doc/bcd_divider.md
# bcd_divider

Sequential 7-digit packed-BCD long divider: the inverse operation of the team's combinational 7×7-digit BCD multiplier. It computes quotient and remainder digit by digit, most significant digit first, using restoring decimal subtraction. It reuses no multiplier rows and runs with a fixed latency so that scheduling in the decimal datapath stays deterministic.

## Interface

- No parameters. Digit count is fixed at 7, giving 28-bit BCD operands.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request. Accepted only on a rising edge where `busy`=0.
- `dividend`  input  28  7 BCD digits, digit 0 in [3:0]. Sampled on the accepting edge.
- `divisor`  input  28  7 BCD digits. Sampled on the accepting edge.
- `busy`  output  1  high while a division is in progress.
- `done`  output  1  one-cycle pulse when results are valid.
- `quotient`  output  28  BCD quotient. Held until the next `done`.
- `remainder`  output  28  BCD remainder. Held until the next `done`.
- `div_by_zero`  output  1  flag for the last result. Held until the next `done`.
- `invalid`  output  1  flag set when an operand nibble is greater than 9. Held until the next `done`.

## Operation

- States: IDLE, SHIFT, SUB, FINISH.
- **IDLE**: on `start`, latch both operands and check them.
  - Any nibble greater than 9 in either operand: go to FINISH with `invalid`=1, quotient=0, remainder=0.
  - Else if divisor=0: go to FINISH with `div_by_zero`=1, quotient=0x9999999, remainder=dividend.
  - Otherwise: clear the partial remainder PR and the quotient, set digit index d=6, go to SHIFT.
- **PR** is 8 BCD digits (32 bits), because PR < divisor ≤ 9999999 and PR·10+9 < 10^8.
- **SHIFT** (1 cycle): PR ← {PR[27:0], dividend digit d}; qd ← 0; go to SUB with the attempt counter set to 0.
- **SUB** (exactly 9 cycles per digit): each cycle compute PR − {0,divisor} in BCD (nines-complement plus BCD add, 8 digits).
  - No borrow: PR ← difference and qd ← qd+1.
  - Borrow: hold PR and qd.
  - After the 9th attempt: write qd into quotient digit d. If d=0, go to FINISH; else set d ← d−1 and go to SHIFT.
  - qd never exceeds 9, because PR < 10·divisor holds by construction.
- **FINISH** (1 cycle): register the outputs. `remainder` ← PR[27:0], since PR[31:28] is always 0 here. Pulse `done`, clear `busy`, return to IDLE.
- Output flag rules:
  - `invalid` takes priority over `div_by_zero`.
  - A normal result clears both flags.
- `start` while `busy`=1 is ignored, and the operand inputs are don't-care during that time.
- The `done` cycle is an IDLE cycle. A `start` seen on the edge that ends the `done` cycle is accepted, so back-to-back operation is supported.
- Reset (asynchronous, any state, including mid-division):
  - state → IDLE.
  - `busy`, `done`, `div_by_zero`, `invalid` → 0.
  - `quotient`, `remainder`, PR and the digit counters → 0.
  - A division interrupted by reset produces no `done`.

## Timing

- Let the accepting edge be E0.
- Normal division:
  - `busy`=1 from after E0 until the FINISH edge.
  - The 7 digits take 7×10 = 70 cycles (E1..E70).
  - FINISH is entered at E70. The outputs update and `done`=1 after E71, for exactly one cycle.
  - Total latency is 71 cycles, independent of the data.
- Invalid operand or divide by zero:
  - FINISH at E1; outputs and `done` are valid after E2.
  - `busy`=1 for 1 cycle.
- Result outputs change only on the edge that raises `done`.
- No combinational path from the inputs to any output.

## Test plan

- **Normal division**: 1234567 / 0000123 → `done` one cycle after the 71st edge, quotient=0x0010037, remainder=0x0000016, both flags 0.
- **Maximum quotient and dividend smaller than divisor**:
  - 9999999 / 0000001 → quotient=0x9999999, remainder=0.
  - 0000005 / 0000007 → quotient=0, remainder=0x0000005.
- **Divide by zero**: 0004321 / 0000000 → `done` after E2, `div_by_zero`=1, quotient=0x9999999, remainder=0x0004321.
- **Invalid operand**:
  - dividend=0x000000A, divisor=0x0000003 → `invalid`=1, quotient=0, remainder=0, `done` after E2.
  - Same invalid dividend with divisor=0 → `invalid`=1, `div_by_zero`=0.
- **Back-to-back and busy handling**:
  - Pulse `start` at cycle 20 of a busy division with different operands → the request is ignored and the first result is unchanged.
  - Assert `start` during the `done` cycle with 0000100 / 0000010 → accepted; second `done` 71 cycles later with quotient=0x0000010, remainder=0.
- **Reset mid-operation**:
  - Drop `rst_n` at cycle 30 of a division → all outputs 0 immediately, no `done`.
  - After release, 0000050 / 0000007 → quotient=0x0000007, remainder=0x0000001.
